// File: rtl/inst_fetch.sv
// IF stage: assembles each 32-bit instruction from four little-endian byte reads; 5 cycles minimum per instruction with single-cycle memory.
// stall_i holds the presented pair and branch_i redirects from any state; define INST_BUF_EN for a one-entry prefetch buffer.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy_i,
  input  logic                  stall_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [7:0]            mem_rdata_i,
  input  logic                  mem_rvalid_i,
  output logic                  inst_valid_o,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_FLUSH} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [1:0]            r_cnt, w_cnt_nxt;
  logic [23:0]           r_asm, w_asm_nxt, w_asm_cap;
  logic [31:0]           r_inst, w_inst_nxt;
  logic [ADDR_WIDTH-1:0] r_pc_o, w_pc_o_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  w_req, w_take, w_last, w_handoff;
  logic [31:0]           w_word;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic                  w_unused;
`ifdef INST_BUF_EN
  logic                  r_buf_vld, w_buf_vld_nxt;
  logic [31:0]           r_buf_inst, w_buf_inst_nxt;
  logic [ADDR_WIDTH-1:0] r_buf_pc, w_buf_pc_nxt;
`endif

  assign w_unused  = ^branch_target_i[1:0];
  assign w_word    = {mem_rdata_i, r_asm};
  assign w_pc_inc  = r_pc + ADDR_WIDTH'(4);
  assign w_handoff = r_valid && !stall_i;
`ifdef INST_BUF_EN
  assign w_req     = (r_state == S_FETCH) || ((r_state == S_PRESENT) && !r_buf_vld);
`else
  assign w_req     = (r_state == S_FETCH);
`endif
  assign w_take    = w_req && mem_rvalid_i;
  assign w_last    = w_take && (r_cnt == 2'd3);

  assign mem_req_o    = w_req;
  assign mem_addr_o   = w_req ? (r_pc + ADDR_WIDTH'(r_cnt)) : '0;
  assign inst_valid_o = r_valid;
  assign inst_o       = r_inst;
  assign pc_o         = r_pc_o;

  always_comb begin
    w_asm_cap = r_asm;
    case (r_cnt)
      2'd0:    w_asm_cap[7:0]   = mem_rdata_i;
      2'd1:    w_asm_cap[15:8]  = mem_rdata_i;
      2'd2:    w_asm_cap[23:16] = mem_rdata_i;
      default: w_asm_cap        = r_asm;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_asm_nxt   = r_asm;
    w_inst_nxt  = r_inst;
    w_pc_o_nxt  = r_pc_o;
    w_valid_nxt = r_valid;
`ifdef INST_BUF_EN
    w_buf_vld_nxt  = r_buf_vld;
    w_buf_inst_nxt = r_buf_inst;
    w_buf_pc_nxt   = r_buf_pc;
`endif
    if (branch_i) begin
      // redirect wins over stall and drops any byte returning this cycle
      w_state_nxt = S_FLUSH;
      w_pc_nxt    = {branch_target_i[ADDR_WIDTH-1:2], 2'b00};
      w_cnt_nxt   = '0;
      w_valid_nxt = 1'b0;
`ifdef INST_BUF_EN
      w_buf_vld_nxt = 1'b0;
`endif
    end else begin
      if (w_take) begin
        w_asm_nxt = w_asm_cap;
        w_cnt_nxt = r_cnt + 2'd1;
      end
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = '0;
        end
        S_FETCH: begin
          if (w_last) begin
            w_inst_nxt  = w_word;
            w_pc_o_nxt  = r_pc;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_PRESENT;
`ifdef INST_BUF_EN
            w_pc_nxt    = w_pc_inc;
`endif
          end
        end
        S_PRESENT: begin
`ifdef INST_BUF_EN
          // r_pc already points past the presented word; it tracks the prefetch
          if (w_handoff) begin
            if (r_buf_vld) begin
              w_inst_nxt    = r_buf_inst;
              w_pc_o_nxt    = r_buf_pc;
              w_buf_vld_nxt = 1'b0;
            end else if (w_last) begin
              w_inst_nxt = w_word;
              w_pc_o_nxt = r_pc;
              w_pc_nxt   = w_pc_inc;
            end else begin
              w_valid_nxt = 1'b0;
              w_state_nxt = S_FETCH;
            end
          end else if (w_last) begin
            w_buf_inst_nxt = w_word;
            w_buf_pc_nxt   = r_pc;
            w_buf_vld_nxt  = 1'b1;
            w_pc_nxt       = w_pc_inc;
          end
`else
          if (w_handoff) begin
            w_pc_nxt    = w_pc_inc;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_FETCH;
          end
`endif
        end
        default: w_state_nxt = S_FETCH; // S_FLUSH: request dropped for one cycle
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
      r_asm   <= '0;
      r_inst  <= '0;
      r_pc_o  <= '0;
      r_valid <= 1'b0;
`ifdef INST_BUF_EN
      r_buf_vld  <= 1'b0;
      r_buf_inst <= '0;
      r_buf_pc   <= '0;
`endif
    end else if (rdy_i) begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_asm   <= w_asm_nxt;
      r_inst  <= w_inst_nxt;
      r_pc_o  <= w_pc_o_nxt;
      r_valid <= w_valid_nxt;
`ifdef INST_BUF_EN
      r_buf_vld  <= w_buf_vld_nxt;
      r_buf_inst <= w_buf_inst_nxt;
      r_buf_pc   <= w_buf_pc_nxt;
`endif
    end
  end

endmodule
